// File: rtl/decode_stage.sv
// WISC ID stage: decode, 16x16 register file with write-through, load-use
// hazard detection, flush bubbles, HLT latch, and the ID/EX pipeline register.
module decode_stage #(
  parameter int unsigned NREG = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [15:0] if_instr,
  input  logic [15:0] if_pc_inc,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [3:0]  wb_addr,
  input  logic [15:0] wb_data,
  output logic        stall,
  output logic        halted,
  output logic        ex_valid,
  output logic [15:0] ex_instr,
  output logic [15:0] ex_imm,
  output logic        ex_alusrc,
  output logic [15:0] ex_regdata1,
  output logic [15:0] ex_regdata2,
  output logic [15:0] ex_pc_inc,
  output logic [3:0]  ex_rd,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_RED = 4'h3,
    OP_SLL  = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6, OP_PADD = 4'h7,
    OP_LW   = 4'h8, OP_SW  = 4'h9, OP_LLB = 4'hA, OP_LHB = 4'hB,
    OP_B    = 4'hC, OP_BR  = 4'hD, OP_PCS = 4'hE, OP_HLT = 4'hF
  } op_t;

  op_t         op;
  logic [3:0]  rd_f, rs_f, rt_f;
  logic [3:0]  raddr1, raddr2;
  logic [15:0] rdata1, rdata2;
  logic [15:0] imm;
  logic        alusrc, regwrite, uses1, uses2;
  logic        hazard, advance;
  logic [15:0] regs [NREG];

  assign op   = op_t'(if_instr[15:12]);
  assign rd_f = if_instr[11:8];
  assign rs_f = if_instr[7:4];
  assign rt_f = if_instr[3:0];

  always_comb begin
    raddr1   = rs_f;
    raddr2   = rt_f;
    imm      = '0;
    alusrc   = 1'b0;
    regwrite = 1'b0;
    uses1    = 1'b0;
    uses2    = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADD: begin
        regwrite = 1'b1;
        uses1    = 1'b1;
        uses2    = 1'b1;
      end
      OP_SLL, OP_SRA, OP_ROR: begin
        imm      = {12'h000, if_instr[3:0]};
        alusrc   = 1'b1;
        regwrite = 1'b1;
        uses1    = 1'b1;
      end
      OP_LW: begin
        imm      = {{11{if_instr[3]}}, if_instr[3:0], 1'b0};
        alusrc   = 1'b1;
        regwrite = 1'b1;
        uses1    = 1'b1;
      end
      OP_SW: begin
        raddr2 = rd_f;
        imm    = {{11{if_instr[3]}}, if_instr[3:0], 1'b0};
        alusrc = 1'b1;
        uses1  = 1'b1;
        uses2  = 1'b1;
      end
      OP_LLB, OP_LHB: begin
        // byte loads merge into the existing rd value, so rd is source 1
        raddr1   = rd_f;
        imm      = {8'h00, if_instr[7:0]};
        alusrc   = 1'b1;
        regwrite = 1'b1;
        uses1    = 1'b1;
      end
      OP_B:   imm = {{7{if_instr[8]}}, if_instr[8:0]};
      OP_BR:  uses1 = 1'b1;
      OP_PCS: regwrite = 1'b1;
      OP_HLT: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_we && wb_addr != 4'd0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != 4'd0) rdata1 = (wb_we && wb_addr == raddr1) ? wb_data : regs[raddr1];
    if (raddr2 != 4'd0) rdata2 = (wb_we && wb_addr == raddr2) ? wb_data : regs[raddr2];
  end

  assign hazard = if_valid & ex_valid & ex_memread & (ex_rd != 4'd0) &
                  ((uses1 & (raddr1 == ex_rd)) | (uses2 & (raddr2 == ex_rd)));
  assign stall   = halted | (hazard & ~flush);
  assign advance = if_valid & ~flush & ~hazard & ~halted;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted      <= 1'b0;
      ex_valid    <= 1'b0;
      ex_instr    <= '0;
      ex_imm      <= '0;
      ex_alusrc   <= 1'b0;
      ex_regdata1 <= '0;
      ex_regdata2 <= '0;
      ex_pc_inc   <= '0;
      ex_rd       <= '0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
    end else if (advance) begin
      if (op == OP_HLT) halted <= 1'b1;
      ex_valid    <= 1'b1;
      ex_instr    <= if_instr;
      ex_imm      <= imm;
      ex_alusrc   <= alusrc;
      ex_regdata1 <= rdata1;
      ex_regdata2 <= rdata2;
      ex_pc_inc   <= if_pc_inc;
      ex_rd       <= rd_f;
      ex_regwrite <= regwrite;
      ex_memread  <= (op == OP_LW);
      ex_memwrite <= (op == OP_SW);
    end else begin
      ex_valid    <= 1'b0;
      ex_instr    <= '0;
      ex_imm      <= '0;
      ex_alusrc   <= 1'b0;
      ex_regdata1 <= '0;
      ex_regdata2 <= '0;
      ex_pc_inc   <= '0;
      ex_rd       <= '0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed scoreboard bench for decode_stage: expected ID/EX contents are
// queued when an instruction is presented and checked after the clock edge.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc_inc;
  logic        flush;
  logic        wb_we;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        stall, halted, ex_valid, ex_alusrc, ex_regwrite, ex_memread, ex_memwrite;
  logic [15:0] ex_instr, ex_imm, ex_regdata1, ex_regdata2, ex_pc_inc;
  logic [3:0]  ex_rd;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        valid;
    logic [15:0] instr;
    logic [15:0] imm;
    logic        alusrc;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] pc;
    logic [3:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
  } exp_t;

  exp_t sb[$];

  decode_stage #(.NREG(16)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc_inc(if_pc_inc), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .stall(stall), .halted(halted), .ex_valid(ex_valid),
    .ex_instr(ex_instr), .ex_imm(ex_imm), .ex_alusrc(ex_alusrc),
    .ex_regdata1(ex_regdata1), .ex_regdata2(ex_regdata2), .ex_pc_inc(ex_pc_inc),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                       input logic fl, input logic we, input logic [3:0] wa,
                       input logic [15:0] wd);
    if_valid = v; if_instr = ins; if_pc_inc = pc; flush = fl;
    wb_we = we; wb_addr = wa; wb_data = wd;
  endtask

  task automatic push_op(input logic [15:0] ins, input logic [15:0] imm, input logic als,
                         input logic [15:0] r1, input logic [15:0] r2, input logic [15:0] pc,
                         input logic [3:0] rd, input logic rw, input logic mr, input logic mw);
    exp_t e;
    e.valid = 1'b1; e.instr = ins; e.imm = imm; e.alusrc = als; e.rd1 = r1; e.rd2 = r2;
    e.pc = pc; e.rd = rd; e.rw = rw; e.mr = mr; e.mw = mw;
    sb.push_back(e);
  endtask

  task automatic push_bubble();
    exp_t e;
    e.valid = 1'b0; e.instr = '0; e.imm = '0; e.alusrc = 1'b0; e.rd1 = '0; e.rd2 = '0;
    e.pc = '0; e.rd = '0; e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0;
    sb.push_back(e);
  endtask

  // advance one clock and compare the ID/EX register against the scoreboard head
  task automatic step(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    tests++;
    assert (sb.size() != 0) else begin
      fails++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_valid"}, {15'd0, ex_valid}, {15'd0, e.valid});
      chk({tag, "_rw"}, {15'd0, ex_regwrite}, {15'd0, e.rw});
      chk({tag, "_mr"}, {15'd0, ex_memread}, {15'd0, e.mr});
      chk({tag, "_mw"}, {15'd0, ex_memwrite}, {15'd0, e.mw});
      if (e.valid) begin
        chk({tag, "_instr"}, ex_instr, e.instr);
        chk({tag, "_imm"}, ex_imm, e.imm);
        chk({tag, "_alusrc"}, {15'd0, ex_alusrc}, {15'd0, e.alusrc});
        chk({tag, "_rd1"}, ex_regdata1, e.rd1);
        chk({tag, "_rd2"}, ex_regdata2, e.rd2);
        chk({tag, "_pc"}, ex_pc_inc, e.pc);
        chk({tag, "_rd"}, {12'd0, ex_rd}, {12'd0, e.rd});
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000);
    #2;
    chk("rst_valid", {15'd0, ex_valid}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_rw", {15'd0, ex_regwrite}, 16'd0);
    @(negedge clk);
    rst = 1'b1;

    // write-through: r3 written in the same cycle ADD r1,r3,r4 reads it
    drive(1'b1, 16'h0134, 16'h0002, 1'b0, 1'b1, 4'd3, 16'h1234);
    #1 chk("wt_stall", {15'd0, stall}, 16'd0);
    push_op(16'h0134, 16'h0000, 1'b0, 16'h1234, 16'h0000, 16'h0002, 4'd1, 1'b1, 1'b0, 1'b0);
    step("wt");

    // preload r5 and r4 with no instruction in ID; writes to r0 are dropped
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 4'd5, 16'h0050);
    push_bubble();
    step("pre5");
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 4'd4, 16'h0044);
    push_bubble();
    step("pre4");
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 4'd0, 16'hDEAD);
    push_bubble();
    step("pre0");

    // LW r2,[r5,#-1]
    drive(1'b1, 16'h825F, 16'h0004, 1'b0, 1'b0, 4'd0, 16'h0000);
    push_op(16'h825F, 16'hFFFE, 1'b1, 16'h0050, 16'h0000, 16'h0004, 4'd2, 1'b1, 1'b1, 1'b0);
    step("lw");

    // load-use: ADD r1,r2,r3 behind LW r2 stalls one cycle
    drive(1'b1, 16'h0123, 16'h0006, 1'b0, 1'b0, 4'd0, 16'h0000);
    #1 chk("lu_stall", {15'd0, stall}, 16'd1);
    push_bubble();
    step("lu_bub");
    drive(1'b1, 16'h0123, 16'h0006, 1'b0, 1'b1, 4'd2, 16'hBEEF);
    #1 chk("lu_release", {15'd0, stall}, 16'd0);
    push_op(16'h0123, 16'h0000, 1'b0, 16'hBEEF, 16'h1234, 16'h0006, 4'd1, 1'b1, 1'b0, 1'b0);
    step("lu_add");

    // LW r2,[r5,#0], then LLB r7 (reads r7 only) must not stall
    drive(1'b1, 16'h8250, 16'h0008, 1'b0, 1'b0, 4'd0, 16'h0000);
    push_op(16'h8250, 16'h0000, 1'b1, 16'h0050, 16'h0000, 16'h0008, 4'd2, 1'b1, 1'b1, 1'b0);
    step("lw2");
    drive(1'b1, 16'hA7AB, 16'h000A, 1'b0, 1'b0, 4'd0, 16'h0000);
    #1 chk("llb_stall", {15'd0, stall}, 16'd0);
    push_op(16'hA7AB, 16'h00AB, 1'b1, 16'h0000, 16'h0000, 16'h000A, 4'd7, 1'b1, 1'b0, 1'b0);
    step("llb");

    // B with 9-bit immediate 1FF
    drive(1'b1, 16'hC1FF, 16'h000C, 1'b0, 1'b0, 4'd0, 16'h0000);
    push_op(16'hC1FF, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 16'h000C, 4'd1, 1'b0, 1'b0, 1'b0);
    step("br");

    // SW r3,[r4,#5]: source 2 comes from [11:8]
    drive(1'b1, 16'h9345, 16'h000E, 1'b0, 1'b0, 4'd0, 16'h0000);
    push_op(16'h9345, 16'h000A, 1'b1, 16'h0044, 16'h1234, 16'h000E, 4'd3, 1'b0, 1'b0, 1'b1);
    step("sw");

    // flush together with load-use hazard
    drive(1'b1, 16'h8250, 16'h0010, 1'b0, 1'b0, 4'd0, 16'h0000);
    push_op(16'h8250, 16'h0000, 1'b1, 16'h0050, 16'h0000, 16'h0010, 4'd2, 1'b1, 1'b1, 1'b0);
    step("lw3");
    drive(1'b1, 16'h0123, 16'h0012, 1'b1, 1'b0, 4'd0, 16'h0000);
    #1 chk("fl_stall", {15'd0, stall}, 16'd0);
    push_bubble();
    step("fl_haz");

    // flushed HLT does not latch
    drive(1'b1, 16'hF000, 16'h0014, 1'b1, 1'b0, 4'd0, 16'h0000);
    push_bubble();
    step("fl_hlt");
    chk("fl_hlt_halted", {15'd0, halted}, 16'd0);

    // HLT advances
    drive(1'b1, 16'hF000, 16'h0016, 1'b0, 1'b0, 4'd0, 16'h0000);
    #1 chk("hlt_pre_stall", {15'd0, stall}, 16'd0);
    push_op(16'hF000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0016, 4'd0, 1'b0, 1'b0, 1'b0);
    step("hlt");
    chk("hlt_halted", {15'd0, halted}, 16'd1);
    chk("hlt_stall", {15'd0, stall}, 16'd1);

    // halted: only bubbles, writes still land
    drive(1'b1, 16'h0134, 16'h0018, 1'b0, 1'b1, 4'd4, 16'h4444);
    push_bubble();
    step("h1");
    drive(1'b1, 16'h0134, 16'h0018, 1'b0, 1'b1, 4'd1, 16'h1111);
    push_bubble();
    step("h2");
    chk("h2_halted", {15'd0, halted}, 16'd1);
    chk("h2_stall", {15'd0, stall}, 16'd1);

    // asynchronous reset between edges
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000);
    #2 rst = 1'b0;
    #1;
    chk("arst_halted", {15'd0, halted}, 16'd0);
    chk("arst_valid", {15'd0, ex_valid}, 16'd0);
    chk("arst_rw", {15'd0, ex_regwrite}, 16'd0);
    @(negedge clk);
    rst = 1'b1;

    // ADD r2,r1,r0 after reset: r1 was cleared
    drive(1'b1, 16'h0210, 16'h0020, 1'b0, 1'b0, 4'd0, 16'h0000);
    push_op(16'h0210, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0020, 4'd2, 1'b1, 1'b0, 1'b0);
    step("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
